// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared types and constants for the load/store lane: FSM state encoding,
// fault cause codes, RISC-V funct3 size/sign encodings and an access-size
// decode helper. Imported by lsu_align, lsu_unit and the testbench.
// -----------------------------------------------------------------------------
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } lsu_state_t;

  typedef enum logic [1:0] {
    FAULT_LD_MISALIGN  = 2'd0,
    FAULT_ST_MISALIGN  = 2'd1,
    FAULT_ACCESS       = 2'd2,
    FAULT_ILLEGAL_SIZE = 2'd3
  } lsu_fault_e;

  typedef enum logic [1:0] {
    SIZE_B = 2'd0,
    SIZE_H = 2'd1,
    SIZE_W = 2'd2,
    SIZE_D = 2'd3
  } lsu_size_e;

  // Load encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  // Store encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

  // funct3[1:0] is log2 of the access size in bytes; funct3[2] selects
  // zero-extension for loads.
  function automatic lsu_size_e size_of(input logic [2:0] funct3);
    return lsu_size_e'(funct3[1:0]);
  endfunction

endpackage

// File: rtl/lsu_if.sv
// -----------------------------------------------------------------------------
// lsu_if
// Handshaked, variable-latency data-memory bus between the load/store lane
// (master) and the data memory (slave).
//   req    master->slave  request valid, held until gnt
//   gnt    slave->master  request accepted this cycle
//   addr   master->slave  lane-aligned address
//   we     master->slave  write enable
//   be     master->slave  byte enables (XLEN/8 lanes)
//   wdata  master->slave  replicated store data
//   rvalid slave->master  response valid (load data or store ack)
//   rdata  slave->master  load data
//   err    slave->master  bus error, qualified by rvalid
// -----------------------------------------------------------------------------
interface lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) ();

  localparam int NB = XLEN / 8;

  logic              req;
  logic              gnt;
  logic [ADDR_W-1:0] addr;
  logic              we;
  logic [NB-1:0]     be;
  logic [XLEN-1:0]   wdata;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;
  logic              err;

  modport master (
    output req, addr, we, be, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, addr, we, be, wdata,
    output gnt, rvalid, rdata, err
  );

endinterface

// File: rtl/lsu_align.sv
// -----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane logic for the load/store lane.
// Request side (from issue):
//   req_funct3, req_addr_lo, req_wdata -> illegal, misaligned, be, wdata
// Response side (from captured op + memory):
//   ld_funct3, ld_off, rdata           -> ld_data (shifted, sign/zero extended)
// -----------------------------------------------------------------------------
module lsu_align
  import lsu_pkg::*;
#(
  parameter  int XLEN = 32,
  localparam int NB   = XLEN / 8,
  localparam int OFFW = $clog2(NB)
) (
  input  logic [2:0]      req_funct3,
  input  logic [2:0]      req_addr_lo,
  input  logic [XLEN-1:0] req_wdata,
  output logic            illegal,
  output logic            misaligned,
  output logic [NB-1:0]   be,
  output logic [XLEN-1:0] wdata,
  input  logic [2:0]      ld_funct3,
  input  logic [OFFW-1:0] ld_off,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] ld_data
);

  lsu_size_e       req_size;
  lsu_size_e       ld_size;
  logic [7:0]      size_mask;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] keep_mask;
  logic            sign_bit;

  assign req_size = size_of(req_funct3);
  assign ld_size  = size_of(ld_funct3);

  // Doubleword and LWU only exist on a 64-bit lane; 111 is never legal.
  assign illegal = (req_funct3 == 3'b111) ||
                   ((XLEN == 32) && ((req_funct3 == LD) || (req_funct3 == LWU)));

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    misaligned = 1'b0;
    size_mask  = 8'h01;
    unique case (req_size)
      SIZE_B: begin misaligned = 1'b0;              size_mask = 8'h01; end
      SIZE_H: begin misaligned = req_addr_lo[0];    size_mask = 8'h03; end
      SIZE_W: begin misaligned = |req_addr_lo[1:0]; size_mask = 8'h0F; end
      SIZE_D: begin misaligned = |req_addr_lo;      size_mask = 8'hFF; end
    endcase
  end

  // On a 32-bit lane only SIZE_D would lose mask bits, and it is illegal there.
  assign be = NB'(size_mask) << req_addr_lo[OFFW-1:0];

  // Replicating the low bytes across every lane means the memory picks the
  // right copy purely from be, with no data shifter on the store path.
  always_comb begin
    wdata = req_wdata;
    case (req_size)
      SIZE_B:  wdata = {NB{req_wdata[7:0]}};
      SIZE_H:  wdata = {(NB/2){req_wdata[15:0]}};
      SIZE_W:  wdata = {(NB/4){req_wdata[31:0]}};
      default: wdata = req_wdata;
    endcase
  end

  assign shifted = rdata >> {ld_off, 3'b000};

  always_comb begin
    keep_mask = '1;
    sign_bit  = shifted[XLEN-1];
    case (ld_size)
      SIZE_B:  begin keep_mask = XLEN'(8'hFF);         sign_bit = shifted[7];  end
      SIZE_H:  begin keep_mask = XLEN'(16'hFFFF);      sign_bit = shifted[15]; end
      SIZE_W:  begin keep_mask = XLEN'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
      default: ;
    endcase
  end

  assign ld_data = (shifted & keep_mask) |
                   ((sign_bit && !ld_funct3[2]) ? ~keep_mask : '0);

endmodule

// File: rtl/lsu_unit.sv
// -----------------------------------------------------------------------------
// lsu_unit
// Load/store execution lane: accepts one decoded memory op from issue, drives
// a handshaked variable-latency data-memory bus, and emits a formatted load
// writeback or a fault as one-cycle registered pulses.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   req_valid/req_ready   issue handshake (ready only while IDLE)
//   req_store, req_funct3, req_addr, req_wdata, req_rd   decoded op
//   flush                 kill in-flight op / block acceptance
//   dmem                  lsu_if master port to data memory
//   wb_valid, wb_rd, wb_data              load writeback pulse
//   fault_valid, fault_cause, fault_addr  exception pulse
//   busy                  op in flight
// -----------------------------------------------------------------------------
module lsu_unit
  import lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int RD_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  input  logic              flush,
  lsu_if.master             dmem,
  output logic              wb_valid,
  output logic [RD_W-1:0]   wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              fault_valid,
  output logic [1:0]        fault_cause,
  output logic [ADDR_W-1:0] fault_addr,
  output logic              busy
);

  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_t        state;
  logic              accept;

  // Captured op
  logic              op_store;
  logic [2:0]        op_funct3;
  logic [ADDR_W-1:0] op_addr;
  logic [RD_W-1:0]   op_rd;
  logic              killed;

  // Registered bus outputs
  logic              dreq_q;
  logic [ADDR_W-1:0] daddr_q;
  logic              dwe_q;
  logic [NB-1:0]     dbe_q;
  logic [XLEN-1:0]   dwdata_q;

  // Lane logic results
  logic              illegal;
  logic              misaligned;
  logic [NB-1:0]     be;
  logic [XLEN-1:0]   wdata_rep;
  logic [XLEN-1:0]   ld_data;

  lsu_align #(.XLEN(XLEN)) u_align (
    .req_funct3  (req_funct3),
    .req_addr_lo (req_addr[2:0]),
    .req_wdata   (req_wdata),
    .illegal     (illegal),
    .misaligned  (misaligned),
    .be          (be),
    .wdata       (wdata_rep),
    .ld_funct3   (op_funct3),
    .ld_off      (op_addr[OFFW-1:0]),
    .rdata       (dmem.rdata),
    .ld_data     (ld_data)
  );

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready && !flush;

  assign dmem.req   = dreq_q;
  assign dmem.addr  = daddr_q;
  assign dmem.we    = dwe_q;
  assign dmem.be    = dbe_q;
  assign dmem.wdata = dwdata_q;

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // in this block samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      op_store    <= 1'b0;
      op_funct3   <= '0;
      op_addr     <= '0;
      op_rd       <= '0;
      killed      <= 1'b0;
      dreq_q      <= 1'b0;
      daddr_q     <= '0;
      dwe_q       <= 1'b0;
      dbe_q       <= '0;
      dwdata_q    <= '0;
      wb_valid    <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      fault_valid <= 1'b0;
      fault_cause <= '0;
      fault_addr  <= '0;
    end else begin
      // Result outputs are single-cycle pulses.
      wb_valid    <= 1'b0;
      fault_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (accept) begin
            op_store  <= req_store;
            op_funct3 <= req_funct3;
            op_addr   <= req_addr;
            op_rd     <= req_rd;
            killed    <= 1'b0;
            if (illegal) begin
              fault_valid <= 1'b1;
              fault_cause <= FAULT_ILLEGAL_SIZE;
              fault_addr  <= req_addr;
            end else if (misaligned) begin
              fault_valid <= 1'b1;
              fault_cause <= req_store ? FAULT_ST_MISALIGN : FAULT_LD_MISALIGN;
              fault_addr  <= req_addr;
            end else begin
              state    <= REQ;
              dreq_q   <= 1'b1;
              daddr_q  <= {req_addr[ADDR_W-1:OFFW], {OFFW{1'b0}}};
              dwe_q    <= req_store;
              dbe_q    <= be;
              dwdata_q <= wdata_rep;
            end
          end
        end

        // A request already on the bus cannot be withdrawn; a flush only
        // marks the op so its response is swallowed.
        REQ: begin
          if (flush) killed <= 1'b1;
          if (dmem.gnt) begin
            dreq_q <= 1'b0;
            state  <= WAIT;
          end
        end

        WAIT: begin
          if (dmem.rvalid) begin
            state  <= IDLE;
            killed <= 1'b0;
            if (!killed && !flush) begin
              if (dmem.err) begin
                fault_valid <= 1'b1;
                fault_cause <= FAULT_ACCESS;
                fault_addr  <= op_addr;
              end else if (!op_store) begin
                wb_valid <= 1'b1;
                wb_rd    <= op_rd;
                wb_data  <= ld_data;
              end
            end
          end else if (flush) begin
            killed <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
